// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: one buffered writeback slot each for the ALU
// and the mult/div unit, committed one per cycle into a single regfile write
// port. The older slot wins; equal-age slots alternate via a round-robin
// pointer.
module regfile_write_arbiter (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        md_valid,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        rf_we,
  output logic [4:0]  rf_reg,
  output logic [31:0] rf_data,
  output logic [31:0] busy_mask,
  output logic [15:0] commit_count
);

  // Relative age of the two slots; meaningful only while both are occupied
  localparam logic [1:0] AGE_TIE       = 2'd0;
  localparam logic [1:0] AGE_ALU_OLDER = 2'd1;
  localparam logic [1:0] AGE_MD_OLDER  = 2'd2;

  logic        alu_occ, md_occ;
  logic [4:0]  alu_reg_q, md_reg_q;
  logic [31:0] alu_data_q, md_data_q;
  logic [1:0]  age_q, age_d;
  logic        rr_q;
  logic [15:0] count_q;

  logic grant_alu, grant_md, tie_grant;
  logic alu_load, md_load, alu_keep, md_keep;

  // Pick the slot to commit this cycle: sole occupant, else older, else rr
  always_comb begin
    grant_alu = 1'b0;
    grant_md  = 1'b0;
    tie_grant = 1'b0;
    if (alu_occ && md_occ) begin
      if (age_q == AGE_ALU_OLDER) begin
        grant_alu = 1'b1;
      end else if (age_q == AGE_MD_OLDER) begin
        grant_md = 1'b1;
      end else begin
        tie_grant = 1'b1;
        if (rr_q) grant_md = 1'b1;
        else      grant_alu = 1'b1;
      end
    end else if (alu_occ) begin
      grant_alu = 1'b1;
    end else if (md_occ) begin
      grant_md = 1'b1;
    end
  end

  assign alu_ready = !alu_occ || grant_alu;
  assign md_ready  = !md_occ  || grant_md;

  // Writes to register 0 are accepted but never occupy a slot
  assign alu_load = alu_valid && alu_ready && (alu_reg != 5'd0);
  assign md_load  = md_valid  && md_ready  && (md_reg  != 5'd0);
  assign alu_keep = alu_occ && !grant_alu;
  assign md_keep  = md_occ  && !grant_md;

  // Next age relation: a slot that loads while the other holds is younger
  always_comb begin
    age_d = AGE_TIE;
    if (alu_load && md_load)       age_d = AGE_TIE;
    else if (alu_load && md_keep)  age_d = AGE_MD_OLDER;
    else if (md_load && alu_keep)  age_d = AGE_ALU_OLDER;
    else if (alu_keep && md_keep)  age_d = age_q;
  end

  // Write-port drive straight from the granted slot registers
  always_comb begin
    rf_we   = grant_alu || grant_md;
    rf_reg  = '0;
    rf_data = '0;
    if (grant_alu) begin
      rf_reg  = alu_reg_q;
      rf_data = alu_data_q;
    end else if (grant_md) begin
      rf_reg  = md_reg_q;
      rf_data = md_data_q;
    end
  end

  // Pending-destination mask from registered slot state only
  always_comb begin
    busy_mask = '0;
    if (alu_occ) busy_mask[alu_reg_q] = 1'b1;
    if (md_occ)  busy_mask[md_reg_q]  = 1'b1;
    busy_mask[0] = 1'b0;
  end

  assign commit_count = count_q;

  // Slot, age, round-robin and commit-counter state
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      alu_occ    <= 1'b0;
      md_occ     <= 1'b0;
      alu_reg_q  <= '0;
      md_reg_q   <= '0;
      alu_data_q <= '0;
      md_data_q  <= '0;
      age_q      <= AGE_TIE;
      rr_q       <= 1'b0;
      count_q    <= '0;
    end else begin
      alu_occ <= alu_load || alu_keep;
      md_occ  <= md_load  || md_keep;
      if (alu_load) begin
        alu_reg_q  <= alu_reg;
        alu_data_q <= alu_data;
      end
      if (md_load) begin
        md_reg_q  <= md_reg;
        md_data_q <= md_data;
      end
      age_q <= age_d;
      if (tie_grant) rr_q <= !rr_q;
      if (rf_we) count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: each scenario queues the
// writes it expects in commit order; a negedge monitor pops and compares.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        ctrl_reset;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        rf_we;
  logic [4:0]  rf_reg;
  logic [31:0] rf_data;
  logic [31:0] busy_mask;
  logic [15:0] commit_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_cc = 0;
  logic [36:0] exp_q[$];
  logic [31:0] shadow[32];

  regfile_write_arbiter dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
    .rf_we(rf_we), .rf_reg(rf_reg), .rf_data(rf_data),
    .busy_mask(busy_mask), .commit_count(commit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Commit monitor: every write must match the head of the expected queue
  always @(negedge clock) begin
    logic [36:0] e;
    vectors++;
    if (busy_mask[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_bit0: got %b want 0", busy_mask[0]);
    end
    if (rf_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got reg %0d data %h, want no write", rf_reg, rf_data);
      end else begin
        e = exp_q.pop_front();
        if ({rf_reg, rf_data} !== e) begin
          miscompares++;
          $display("FAIL commit_order: got reg %0d data %h, want reg %0d data %h",
                   rf_reg, rf_data, e[36:32], e[31:0]);
        end
      end
      vectors++;
      if (rf_reg === 5'd0) begin
        miscompares++;
        $display("FAIL write_r0: got rf_reg 0 with rf_we=1, want nonzero");
      end
      shadow[rf_reg] = rf_data;
    end else begin
      vectors++;
      if (rf_we !== 1'b0 || rf_reg !== 5'd0 || rf_data !== 32'd0) begin
        miscompares++;
        $display("FAIL idle_outputs: got we %b reg %0d data %h, want 0/0/0", rf_we, rf_reg, rf_data);
      end
    end
  end

  function automatic void expect_write(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
    exp_cc++;
  endfunction

  // Wait (bounded) for all queued writes to commit, then check the counter
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock); #1;
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d writes outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clock); #1;
    vectors++;
    if (commit_count !== exp_cc[15:0]) begin
      miscompares++;
      $display("FAIL %s_count: got %0d want %0d", name, commit_count, exp_cc);
    end
  endtask

  task automatic test_reset();
    alu_valid = 0; alu_reg = '0; alu_data = '0;
    md_valid = 0;  md_reg = '0;  md_data = '0;
    ctrl_reset = 1'b1;
    #1;
    vectors++;
    if (rf_we !== 1'b0 || rf_reg !== 5'd0 || rf_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_rf: got we %b reg %0d data %h, want 0/0/0", rf_we, rf_reg, rf_data);
    end
    vectors++;
    if (busy_mask !== 32'd0 || commit_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_state: got busy %h count %0d, want 0/0", busy_mask, commit_count);
    end
    vectors++;
    if (alu_ready !== 1'b1 || md_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got alu %b md %b, want 1/1", alu_ready, md_ready);
    end
    @(posedge clock);
    @(negedge clock);
    ctrl_reset = 1'b0;
    exp_q.delete();
    exp_cc = 0;
  endtask

  task automatic test_alu_only();
    test_reset();
    alu_valid = 1; alu_reg = 5'd5; alu_data = 32'h0000_00AA;
    expect_write(5'd5, 32'h0000_00AA);
    #1;
    vectors++;
    if (alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL alu_only_ready: got %b want 1", alu_ready);
    end
    @(posedge clock); #1;
    alu_valid = 0;
    @(negedge clock);
    vectors++;
    if (rf_we !== 1'b1 || busy_mask !== 32'h0000_0020 || commit_count !== 16'd0) begin
      miscompares++;
      $display("FAIL alu_only_n1: got we %b busy %h count %0d, want 1/00000020/0", rf_we, busy_mask, commit_count);
    end
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if (busy_mask !== 32'd0 || commit_count !== 16'd1) begin
      miscompares++;
      $display("FAIL alu_only_n2: got busy %h count %0d, want 0/1", busy_mask, commit_count);
    end
    drain("alu_only");
  endtask

  task automatic test_simultaneous();
    test_reset();
    alu_valid = 1; alu_reg = 5'd4; alu_data = 32'h11;
    md_valid = 1;  md_reg = 5'd6;  md_data = 32'h22;
    expect_write(5'd4, 32'h11);
    expect_write(5'd6, 32'h22);
    expect_write(5'd6, 32'h33);
    @(posedge clock); #1;
    alu_valid = 0; md_data = 32'h33;
    @(negedge clock);
    vectors++;
    if (md_ready !== 1'b0 || busy_mask !== 32'h0000_0050) begin
      miscompares++;
      $display("FAIL simul_stall: got md_ready %b busy %h, want 0/00000050", md_ready, busy_mask);
    end
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if (md_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_ready_back: got %b want 1", md_ready);
    end
    @(posedge clock); #1;
    md_valid = 0;
    drain("simul");
    // rr now points at MD, so the next tie goes to MD first
    alu_valid = 1; alu_reg = 5'd9;  alu_data = 32'h99;
    md_valid = 1;  md_reg = 5'd10; md_data = 32'hAA;
    expect_write(5'd10, 32'hAA);
    expect_write(5'd9, 32'h99);
    @(posedge clock); #1;
    alu_valid = 0; md_valid = 0;
    drain("simul_rr");
  endtask

  task automatic test_age_priority();
    test_reset();
    alu_valid = 1; alu_reg = 5'd3; alu_data = 32'h30;
    md_valid = 1;  md_reg = 5'd7; md_data = 32'h70;
    expect_write(5'd3, 32'h30);
    expect_write(5'd7, 32'h70);
    expect_write(5'd7, 32'h71);
    expect_write(5'd8, 32'h80);
    @(posedge clock); #1;
    alu_reg = 5'd7; alu_data = 32'h71;
    md_reg = 5'd8;  md_data = 32'h80;
    @(negedge clock);
    vectors++;
    if (md_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL age_md_stall: got %b want 0", md_ready);
    end
    @(posedge clock); #1;
    alu_valid = 0;
    @(negedge clock);
    vectors++;
    if (rf_reg !== 5'd7 || rf_data !== 32'h70) begin
      miscompares++;
      $display("FAIL age_md_first: got reg %0d data %h, want 7/00000070", rf_reg, rf_data);
    end
    @(posedge clock); #1;
    md_valid = 0;
    @(negedge clock);
    vectors++;
    if (rf_reg !== 5'd7 || rf_data !== 32'h71) begin
      miscompares++;
      $display("FAIL age_over_rr: got reg %0d data %h, want 7/00000071", rf_reg, rf_data);
    end
    drain("age");
    vectors++;
    if (shadow[7] !== 32'h71) begin
      miscompares++;
      $display("FAIL age_final_r7: got %h want 00000071", shadow[7]);
    end
  endtask

  task automatic test_zero_reg();
    test_reset();
    alu_valid = 1; alu_reg = 5'd1; alu_data = 32'h1234;
    expect_write(5'd1, 32'h1234);
    @(posedge clock); #1;
    alu_valid = 0;
    drain("zero_pre");
    alu_valid = 1; alu_reg = 5'd0; alu_data = 32'hFFFF_FFFF;
    md_valid = 1;  md_reg = 5'd0;  md_data = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if (alu_ready !== 1'b1 || md_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_ready: got alu %b md %b, want 1/1", alu_ready, md_ready);
    end
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if (rf_we !== 1'b0 || busy_mask !== 32'd0 || alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_discard: got we %b busy %h alu_ready %b, want 0/0/1", rf_we, busy_mask, alu_ready);
    end
    @(posedge clock); #1;
    alu_valid = 0; md_valid = 0;
    @(negedge clock);
    vectors++;
    if (commit_count !== 16'd1) begin
      miscompares++;
      $display("FAIL zero_count: got %0d want 1", commit_count);
    end
    drain("zero");
  endtask

  task automatic test_back_to_back();
    test_reset();
    for (int i = 1; i <= 8; i++) begin
      alu_valid = 1; alu_reg = 5'(i); alu_data = 32'h100 + 32'(i);
      expect_write(5'(i), 32'h100 + 32'(i));
      #1;
      vectors++;
      if (alu_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready_%0d: got %b want 1", i, alu_ready);
      end
      @(posedge clock); #1;
    end
    alu_valid = 0;
    @(posedge clock); #1;
    vectors++;
    if (commit_count !== 16'd8 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_count: got count %0d pending %0d, want 8/0", commit_count, exp_q.size());
    end
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    test_reset();
    alu_valid = 1; alu_reg = 5'd2; alu_data = 32'h222;
    expect_write(5'd2, 32'h222);
    @(posedge clock); #1;
    alu_valid = 0;
    drain("mid_pre");
    alu_valid = 1; alu_reg = 5'd11; alu_data = 32'hB;
    md_valid = 1;  md_reg = 5'd12; md_data = 32'hC;
    @(posedge clock); #1;
    alu_valid = 0; md_valid = 0;
    #1;
    vectors++;
    if (busy_mask !== 32'h0000_1800) begin
      miscompares++;
      $display("FAIL mid_busy: got %h want 00001800", busy_mask);
    end
    ctrl_reset = 1'b1;
    exp_cc = 0;
    #1;
    vectors++;
    if (rf_we !== 1'b0 || busy_mask !== 32'd0 || commit_count !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got we %b busy %h count %0d, want 0/0/0", rf_we, busy_mask, commit_count);
    end
    @(negedge clock); #2;
    ctrl_reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if (rf_we !== 1'b0 || busy_mask !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_after: got we %b busy %h, want 0/0", rf_we, busy_mask);
    end
    drain("mid");
    vectors++;
    if (shadow[11] === 32'hB || shadow[12] === 32'hC) begin
      miscompares++;
      $display("FAIL mid_flushed: got r11 %h r12 %h, want neither written", shadow[11], shadow[12]);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) shadow[r] = '0;
    ctrl_reset = 1'b0;
    alu_valid = 0; alu_reg = '0; alu_data = '0;
    md_valid = 0;  md_reg = '0;  md_data = '0;
    #2;
    test_reset();
    test_alu_only();
    test_simultaneous();
    test_age_priority();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
